block_address_sequencer: RTL

//   Generates SRAM sample addresses for a full image plane, scanned as a raster of BxB blocks
//   (raster inside each block, blocks in raster order).

---
 rtl/block_address_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/block_address_sequencer.sv
// Raster-of-blocks SRAM address generator for one image plane, with valid/ready
// back-pressure and block/frame completion flags.
module block_address_sequencer #(
  parameter int ADDR_W   = 18,
  parameter int BLK_LOG2 = 3,
  parameter int IDX_W    = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_address,
  input  logic [ADDR_W-1:0]     row_stride,
  input  logic [IDX_W-1:0]      blocks_per_row,
  input  logic [IDX_W-1:0]      blocks_per_col,
  input  logic                  ready,
  output logic                  valid,
  output logic [ADDR_W-1:0]     address,
  output logic [2*BLK_LOG2-1:0] sample_idx,
  output logic [IDX_W-1:0]      blk_row,
  output logic [IDX_W-1:0]      blk_col,
  output logic                  block_last,
  output logic                  frame_last,
  output logic                  busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int                  B       = 1 << BLK_LOG2;
  localparam logic [BLK_LOG2-1:0] IN_MAX  = '1;
  localparam logic [BLK_LOG2-1:0] IN_ONE  = BLK_LOG2'(1);
  localparam logic [IDX_W-1:0]    IDX_ONE = IDX_W'(1);
  localparam logic [ADDR_W-1:0]   B_ADDR  = ADDR_W'(B);

  logic [0:0]          state_q, state_d;
  logic [BLK_LOG2-1:0] col_q, col_d, row_q, row_d;
  logic [IDX_W-1:0]    blkCol_q, blkCol_d, blkRow_q, blkRow_d;
  logic [IDX_W-1:0]    bpr_q, bpr_d, bpc_q, bpc_d;
  logic [ADDR_W-1:0]   stride_q, stride_d, strideBlk_q, strideBlk_d;
  logic [ADDR_W-1:0]   blkRowBase_q, blkRowBase_d, rowBase_q, rowBase_d;
  logic [ADDR_W-1:0]   colOff_q, colOff_d, addr_q, addr_d;

  logic lastCol, lastRow, lastBlkCol, lastBlkRow;

  assign lastCol    = (col_q == IN_MAX);
  assign lastRow    = (row_q == IN_MAX);
  assign lastBlkCol = (blkCol_q == bpr_q - IDX_ONE);
  assign lastBlkRow = (blkRow_q == bpc_q - IDX_ONE);

  // rowBase tracks the address of column 0 of the current sample row, blkRowBase
  // the first row of the current block row, so each carry is a single add.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    blkCol_d     = blkCol_q;
    blkRow_d     = blkRow_q;
    bpr_d        = bpr_q;
    bpc_d        = bpc_q;
    stride_d     = stride_q;
    strideBlk_d  = strideBlk_q;
    blkRowBase_d = blkRowBase_q;
    rowBase_d    = rowBase_q;
    colOff_d     = colOff_q;
    case (state_q)
      IDLE: begin
        if (start && (blocks_per_row != '0) && (blocks_per_col != '0)) begin
          state_d      = RUN;
          bpr_d        = blocks_per_row;
          bpc_d        = blocks_per_col;
          stride_d     = row_stride;
          strideBlk_d  = row_stride << BLK_LOG2;
          blkRowBase_d = base_address;
          rowBase_d    = base_address;
          colOff_d     = '0;
          col_d        = '0;
          row_d        = '0;
          blkCol_d     = '0;
          blkRow_d     = '0;
        end
      end
      default: begin
        if (ready) begin
          if (!lastCol) begin
            col_d = col_q + IN_ONE;
          end else begin
            col_d = '0;
            if (!lastRow) begin
              row_d     = row_q + IN_ONE;
              rowBase_d = rowBase_q + stride_q;
            end else begin
              row_d = '0;
              if (!lastBlkCol) begin
                blkCol_d  = blkCol_q + IDX_ONE;
                colOff_d  = colOff_q + B_ADDR;
                rowBase_d = blkRowBase_q;
              end else begin
                blkCol_d = '0;
                colOff_d = '0;
                if (!lastBlkRow) begin
                  blkRow_d     = blkRow_q + IDX_ONE;
                  blkRowBase_d = blkRowBase_q + strideBlk_q;
                  rowBase_d    = blkRowBase_q + strideBlk_q;
                end else begin
                  state_d      = IDLE;
                  blkRow_d     = '0;
                  blkRowBase_d = '0;
                  rowBase_d    = '0;
                end
              end
            end
          end
        end
      end
    endcase
    addr_d = rowBase_d + colOff_d + ADDR_W'(col_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      blkCol_q     <= '0;
      blkRow_q     <= '0;
      bpr_q        <= '0;
      bpc_q        <= '0;
      stride_q     <= '0;
      strideBlk_q  <= '0;
      blkRowBase_q <= '0;
      rowBase_q    <= '0;
      colOff_q     <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      blkCol_q     <= blkCol_d;
      blkRow_q     <= blkRow_d;
      bpr_q        <= bpr_d;
      bpc_q        <= bpc_d;
      stride_q     <= stride_d;
      strideBlk_q  <= strideBlk_d;
      blkRowBase_q <= blkRowBase_d;
      rowBase_q    <= rowBase_d;
      colOff_q     <= colOff_d;
      addr_q       <= addr_d;
    end
  end

  assign valid      = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign address    = addr_q;
  assign sample_idx = {row_q, col_q};
  assign blk_row    = blkRow_q;
  assign blk_col    = blkCol_q;
  assign block_last = valid & lastCol & lastRow;
  assign frame_last = block_last & lastBlkCol & lastBlkRow;

endmodule
